// File: rtl/fpga_srl_fifo.sv
// Shift-register FIFO with a registered valid/ready read stage, sized for SRL/distributed RAM.
// Define SRL_FIFO_BYPASS_EN to let a write into an empty FIFO go straight to the output register.
module fpga_srl_fifo #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 5
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              wr_valid,
    input  logic [DWIDTH-1:0] wr_data,
    output logic              wr_ready,
    output logic              rd_valid,
    output logic [DWIDTH-1:0] rd_data,
    input  logic              rd_ready,
    output logic [AWIDTH:0]   level
);
    localparam int              DEPTH    = 2 ** AWIDTH;
    localparam logic [AWIDTH:0] FULL_CNT = (AWIDTH+1)'(DEPTH);
    localparam logic [AWIDTH:0] CNT_ONE  = (AWIDTH+1)'(1);

    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [AWIDTH:0]   cnt_q, cnt_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DWIDTH-1:0] rd_data_q, rd_data_d;
    logic              wr_en, out_free, pop, bypass, shift_en;
    logic [AWIDTH-1:0] rd_addr;

    assign wr_ready = (cnt_q != FULL_CNT);
    assign wr_en    = wr_valid & wr_ready;
    assign out_free = ~rd_valid_q | rd_ready;
    assign pop      = (cnt_q != '0) & out_free;
`ifdef SRL_FIFO_BYPASS_EN
    assign bypass   = wr_en & (cnt_q == '0) & out_free;
`else
    assign bypass   = 1'b0;
`endif
    assign shift_en = wr_en & ~bypass;

    // At cnt=DEPTH the low bits wrap to 0, so subtracting one still yields DEPTH-1.
    assign rd_addr  = cnt_q[AWIDTH-1:0] - AWIDTH'(1);

    always_ff @(posedge clk) begin
        if (shift_en) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                mem_q[i] <= mem_q[i-1];
            end
            mem_q[0] <= wr_data;
        end
    end

    // Pop reads the pre-shift oldest entry, so a same-cycle write never disturbs it.
    always_comb begin
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        if (pop) begin
            rd_valid_d = 1'b1;
            rd_data_d  = mem_q[rd_addr];
        end else if (bypass) begin
            rd_valid_d = 1'b1;
            rd_data_d  = wr_data;
        end else if (rd_valid_q & rd_ready) begin
            rd_valid_d = 1'b0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        case ({shift_en, pop})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            cnt_q      <= cnt_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign level    = cnt_q + {{AWIDTH{1'b0}}, rd_valid_q};

endmodule

// File: tb/tb_fpga_srl_fifo.sv
// Directed testbench for fpga_srl_fifo (DWIDTH=32, AWIDTH=5).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_fpga_srl_fifo;
    localparam int DWIDTH = 32;
    localparam int AWIDTH = 5;
    localparam int DEPTH  = 32;

    logic              clk      = 1'b0;
    logic              arst_n   = 1'b0;
    logic              wr_valid = 1'b0;
    logic [DWIDTH-1:0] wr_data  = '0;
    logic              rd_ready = 1'b0;
    logic              wr_ready;
    logic              rd_valid;
    logic [DWIDTH-1:0] rd_data;
    logic [AWIDTH:0]   level;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fpga_srl_fifo #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) dut (
        .clk      (clk),
        .arst_n   (arst_n),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_ready (rd_ready),
        .level    (level)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        arst_n = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
        step(); step();
        tests++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL reset_rd_valid got %0b want 0", rd_valid); end
        tests++; if (rd_data !== 32'h0) begin fails++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
        tests++; if (level !== 6'd0) begin fails++; $display("FAIL reset_level got %0d want 0", level); end
        tests++; if (wr_ready !== 1'b1) begin fails++; $display("FAIL reset_wr_ready got %0b want 1", wr_ready); end
        arst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        int n;
        int lat;
`ifdef SRL_FIFO_BYPASS_EN
        lat = 1;
`else
        lat = 2;
`endif
        wr_valid = 1'b1; wr_data = 32'hA5A5_0001; rd_ready = 1'b1;
        step();
        wr_valid = 1'b0;
        n = 1;
        while (rd_valid !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        tests++; if (n != lat) begin fails++; $display("FAIL single_latency got %0d edges want %0d", n, lat); end
        tests++; if (rd_data !== 32'hA5A5_0001) begin fails++; $display("FAIL single_data got %h want a5a50001", rd_data); end
        tests++; if (level !== 6'd1) begin fails++; $display("FAIL single_level_busy got %0d want 1", level); end
        step();
        tests++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL single_rd_valid_after got %0b want 0", rd_valid); end
        tests++; if (level !== 6'd0) begin fails++; $display("FAIL single_level_after got %0d want 0", level); end
        rd_ready = 1'b0;
    endtask

    task automatic test_fill();
        rd_ready = 1'b0;
        for (int i = 0; i <= DEPTH; i++) begin
            tests++; if (wr_ready !== 1'b1) begin fails++; $display("FAIL fill_wr_ready word %0d got %0b want 1", i, wr_ready); end
            wr_valid = 1'b1; wr_data = 32'(i);
            step();
        end
        tests++; if (wr_ready !== 1'b0) begin fails++; $display("FAIL fill_full_wr_ready got %0b want 0", wr_ready); end
        tests++; if (level !== 6'd33) begin fails++; $display("FAIL fill_level got %0d want 33", level); end
        wr_data = 32'hDEAD_BEEF;
        step(); step();
        tests++; if (level !== 6'd33) begin fails++; $display("FAIL fill_held_level got %0d want 33", level); end
        tests++; if (wr_ready !== 1'b0) begin fails++; $display("FAIL fill_held_wr_ready got %0b want 0", wr_ready); end
        tests++; if (rd_data !== 32'h0) begin fails++; $display("FAIL fill_head_stable got %h want 0", rd_data); end
        wr_valid = 1'b0; rd_ready = 1'b1;
        for (int i = 0; i <= DEPTH; i++) begin
            tests++;
            if (rd_valid !== 1'b1 || rd_data !== 32'(i)) begin
                fails++; $display("FAIL fill_drain idx %0d got valid=%0b data=%h want valid=1 data=%h", i, rd_valid, rd_data, 32'(i));
            end
            step();
        end
        tests++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL fill_drained_valid got %0b want 0", rd_valid); end
        tests++; if (level !== 6'd0) begin fails++; $display("FAIL fill_drained_level got %0d want 0", level); end
        rd_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] q[$];
        logic [31:0] exp;
        logic [31:0] nxt;
        nxt = 32'd1000;
        rd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1; wr_data = nxt; q.push_back(nxt); nxt++;
            step();
        end
        tests++; if (level !== 6'd3) begin fails++; $display("FAIL stream_prime_level got %0d want 3", level); end
        rd_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tests++; if (wr_ready !== 1'b1 || rd_valid !== 1'b1) begin
                fails++; $display("FAIL stream_throughput cycle %0d got wr_ready=%0b rd_valid=%0b want 1/1", i, wr_ready, rd_valid);
            end
            tests++; if (level !== 6'd3 && level !== 6'd4) begin
                fails++; $display("FAIL stream_level cycle %0d got %0d want 3 or 4", i, level);
            end
            if (rd_valid === 1'b1) begin
                exp = q.pop_front();
                tests++; if (rd_data !== exp) begin fails++; $display("FAIL stream_order cycle %0d got %h want %h", i, rd_data, exp); end
            end
            wr_valid = 1'b1; wr_data = nxt; q.push_back(nxt); nxt++;
            step();
        end
        wr_valid = 1'b0;
        for (int g = 0; g < 50 && q.size() > 0; g++) begin
            if (rd_valid === 1'b1) begin
                exp = q.pop_front();
                tests++; if (rd_data !== exp) begin fails++; $display("FAIL stream_tail got %h want %h", rd_data, exp); end
            end
            step();
        end
        tests++; if (q.size() != 0) begin fails++; $display("FAIL stream_drain_timeout got %0d left want 0", q.size()); end
        tests++; if (rd_valid !== 1'b0 || level !== 6'd0) begin
            fails++; $display("FAIL stream_empty got valid=%0b level=%0d want 0/0", rd_valid, level);
        end
        rd_ready = 1'b0;
    endtask

    task automatic test_random();
        int unsigned wcnt;
        int unsigned rcnt;
        logic        hold;
        logic [31:0] prev;
        wcnt = 0; rcnt = 0; hold = 1'b0; prev = '0;
        for (int c = 0; c < 10000; c++) begin
            wr_valid = 1'($urandom_range(0, 1));
            rd_ready = 1'($urandom_range(0, 1));
            wr_data  = wcnt;
            if (hold) begin
                tests++; if (rd_valid !== 1'b1 || rd_data !== prev) begin
                    fails++; $display("FAIL rand_stable cycle %0d got valid=%0b data=%h want 1/%h", c, rd_valid, rd_data, prev);
                end
            end
            tests++; if (level !== 6'(wcnt - rcnt) || level > 6'd33) begin
                fails++; $display("FAIL rand_level cycle %0d got %0d want %0d", c, level, wcnt - rcnt);
            end
            if (rd_valid === 1'b1 && rd_ready) begin
                tests++; if (rd_data !== rcnt) begin fails++; $display("FAIL rand_order cycle %0d got %h want %h", c, rd_data, rcnt); end
                rcnt++;
            end
            if (wr_valid && wr_ready === 1'b1) wcnt++;
            hold = rd_valid & ~rd_ready;
            prev = rd_data;
            step();
        end
        wr_valid = 1'b0; rd_ready = 1'b1;
        for (int g = 0; g < 100 && rcnt != wcnt; g++) begin
            if (rd_valid === 1'b1) begin
                tests++; if (rd_data !== rcnt) begin fails++; $display("FAIL rand_drain got %h want %h", rd_data, rcnt); end
                rcnt++;
            end
            step();
        end
        tests++; if (rcnt != wcnt) begin fails++; $display("FAIL rand_count got %0d reads want %0d", rcnt, wcnt); end
        tests++; if (rd_valid !== 1'b0 || level !== 6'd0) begin
            fails++; $display("FAIL rand_empty got valid=%0b level=%0d want 0/0", rd_valid, level);
        end
        rd_ready = 1'b0;
    endtask

    task automatic test_simul_near_full();
        rd_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            wr_valid = 1'b1; wr_data = 32'(200 + i);
            step();
        end
        wr_valid = 1'b0;
        tests++; if (level !== 6'd32) begin fails++; $display("FAIL simul_pre_level got %0d want 32", level); end
        tests++; if (rd_data !== 32'd200) begin fails++; $display("FAIL simul_pre_head got %0d want 200", rd_data); end
        wr_valid = 1'b1; wr_data = 32'd232; rd_ready = 1'b1;
        step();
        wr_valid = 1'b0; rd_ready = 1'b0;
        tests++; if (level !== 6'd32) begin fails++; $display("FAIL simul_level got %0d want 32", level); end
        tests++; if (wr_ready !== 1'b1) begin fails++; $display("FAIL simul_wr_ready got %0b want 1", wr_ready); end
        tests++; if (rd_valid !== 1'b1 || rd_data !== 32'd201) begin
            fails++; $display("FAIL simul_oldest got valid=%0b data=%0d want 1/201", rd_valid, rd_data);
        end
        rd_ready = 1'b1;
        for (int i = 201; i <= 232; i++) begin
            tests++; if (rd_valid !== 1'b1 || rd_data !== 32'(i)) begin
                fails++; $display("FAIL simul_drain got valid=%0b data=%0d want 1/%0d", rd_valid, rd_data, i);
            end
            step();
        end
        tests++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL simul_empty got %0b want 0", rd_valid); end
        rd_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n;
        rd_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            wr_valid = 1'b1; wr_data = 32'(300 + i);
            step();
        end
        tests++; if (level !== 6'd10) begin fails++; $display("FAIL rstmid_pre_level got %0d want 10", level); end
        #3 arst_n = 1'b0;
        #1;
        wr_valid = 1'b0;
        tests++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL rstmid_rd_valid got %0b want 0", rd_valid); end
        tests++; if (rd_data !== 32'h0) begin fails++; $display("FAIL rstmid_rd_data got %h want 0", rd_data); end
        tests++; if (level !== 6'd0) begin fails++; $display("FAIL rstmid_level got %0d want 0", level); end
        tests++; if (wr_ready !== 1'b1) begin fails++; $display("FAIL rstmid_wr_ready got %0b want 1", wr_ready); end
        step(); step();
        @(negedge clk);
        arst_n = 1'b1;
        step();
        tests++; if (level !== 6'd0) begin fails++; $display("FAIL rstmid_post_level got %0d want 0", level); end
        wr_valid = 1'b1; wr_data = 32'h1234; rd_ready = 1'b1;
        step();
        wr_valid = 1'b0;
        n = 0;
        while (rd_valid !== 1'b1 && n < 5) begin
            step();
            n++;
        end
        tests++; if (rd_valid !== 1'b1 || rd_data !== 32'h1234) begin
            fails++; $display("FAIL rstmid_first_word got valid=%0b data=%h want 1/00001234", rd_valid, rd_data);
        end
        step();
        tests++; if (level !== 6'd0) begin fails++; $display("FAIL rstmid_final_level got %0d want 0", level); end
        rd_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_back_to_back();
        test_random();
        test_simul_near_full();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
